regfile_mp: RTL and testbench

Parametrised multi-port register file for the RISC-V datapath; successor to the single-write, two-read register file. It provides `NUM_RD` combinational read ports and two clocked write ports with fixed priority. Register 0 is hardwired to zero. A per-register pending-write scoreboard supports pipeline hazard detection. Optional write-to-read bypass is available. It sits between decode (reads, issue) and writeback (writes, scoreboard clear).

---
 rtl/regfile_mp.sv | 102 ++++++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_mp: multi-port register file with a per-register pending-write   |
// | scoreboard. Optional same-cycle bypass is enabled by REGFILE_BYPASS_EN.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_RD = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en0,
    input  logic [AW-1:0]          wr_addr0,
    input  logic [XLEN-1:0]        wr_data0,
    input  logic                   wr_en1,
    input  logic [AW-1:0]          wr_addr1,
    input  logic [XLEN-1:0]        wr_data1,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [XLEN-1:0]  w_regs [DEPTH];
    logic [DEPTH-1:0] w_busy;

    assign w_regs[0] = '0;
    assign w_busy[0] = 1'b0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        localparam logic [XLEN-1:0] c_init = XLEN'(i);
        localparam logic [AW-1:0]   c_addr = AW'(i);

        logic            w_hit0;
        logic            w_hit1;
        logic            w_issue;
        logic [XLEN-1:0] r_q;
        logic            r_busy;

        assign w_hit0  = wr_en0 && (wr_addr0 == c_addr);
        assign w_hit1  = wr_en1 && (wr_addr1 == c_addr);
        assign w_issue = issue_en && (issue_addr == c_addr);

        // Port 1 takes priority when both ports target this register.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_q <= c_init;
            end else if (w_hit1) begin
                r_q <= wr_data1;
            end else if (w_hit0) begin
                r_q <= wr_data0;
            end
        end

        // A new producer supersedes a completing one, so issue wins over clear.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_busy <= 1'b0;
            end else if (w_issue) begin
                r_busy <= 1'b1;
            end else if (w_hit0 || w_hit1) begin
                r_busy <= 1'b0;
            end
        end

        assign w_regs[i] = r_q;
        assign w_busy[i] = r_busy;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;

        assign w_addr = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset so outputs show reset contents.
        always_comb begin
            w_data = w_regs[w_addr];
            if (!reset && wr_en1 && (wr_addr1 == w_addr)) begin
                w_data = wr_data1;
            end else if (!reset && wr_en0 && (wr_addr0 == w_addr)) begin
                w_data = wr_data0;
            end
        end
`else
        assign w_data = w_regs[w_addr];
`endif

        assign rd_data[k*XLEN +: XLEN] = (w_addr == '0) ? '0 : w_data;
        assign rd_busy[k]              = w_busy[w_addr];
    end

    assign busy_vec = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_mp: randomized scoreboard bench for regfile_mp against an     |
// | array-based reference model. Rev 1.0                                     |
// +--------------------------------------------------------------------------+
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_RD*AW-1:0]   rd_addr = '0;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   wr_en0 = 1'b0;
    logic [AW-1:0]          wr_addr0 = '0;
    logic [XLEN-1:0]        wr_data0 = '0;
    logic                   wr_en1 = 1'b0;
    logic [AW-1:0]          wr_addr1 = '0;
    logic [XLEN-1:0]        wr_data1 = '0;
    logic                   issue_en = 1'b0;
    logic [AW-1:0]          issue_addr = '0;
    logic [DEPTH-1:0]       busy_vec;

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NUM_RD)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en0     (wr_en0),
        .wr_addr0   (wr_addr0),
        .wr_data0   (wr_data0),
        .wr_en1     (wr_en1),
        .wr_addr1   (wr_addr1),
        .wr_data1   (wr_data1),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_vec   (busy_vec)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                     cyc;
        logic [NUM_RD*XLEN-1:0] data;
        logic [NUM_RD-1:0]      rbusy;
        logic [DEPTH-1:0]       bvec;
    } exp_t;

    exp_t q_exp [$];

    // Reference model: plain arrays updated by the architectural rules.
    logic [XLEN-1:0] m_reg  [DEPTH];
    bit              m_busy [DEPTH];

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc    = 0;
    bit drv_done = 1'b0;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i]  = XLEN'(i);
            m_busy[i] = 1'b0;
        end
    endfunction

    task automatic cyc(input logic rst,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic we0, input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                       input logic we1, input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                       input logic ie, input logic [AW-1:0] ia);
        exp_t e;
        logic [AW-1:0] ra [NUM_RD];
        logic [XLEN-1:0] v;
        @(negedge clock);
        reset      = rst;
        rd_addr    = {ra1, ra0};
        wr_en0     = we0;  wr_addr0 = wa0;  wr_data0 = wd0;
        wr_en1     = we1;  wr_addr1 = wa1;  wr_data1 = wd1;
        issue_en   = ie;   issue_addr = ia;
        ra[0] = ra0;
        ra[1] = ra1;
        if (rst) model_reset();
        e.cyc = n_cyc;
        for (int k = 0; k < NUM_RD; k++) begin
            v = m_reg[ra[k]];
`ifdef REGFILE_BYPASS_EN
            if (!rst && we1 && wa1 == ra[k]) v = wd1;
            else if (!rst && we0 && wa0 == ra[k]) v = wd0;
`endif
            if (ra[k] == 0) v = '0;
            e.data[k*XLEN +: XLEN] = v;
            e.rbusy[k] = m_busy[ra[k]];
        end
        for (int i = 0; i < DEPTH; i++) e.bvec[i] = m_busy[i];
        q_exp.push_back(e);
        // State update applied at the coming rising edge.
        if (!rst) begin
            if (we0 && wa0 != 0) begin m_reg[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (ie && ia != 0) m_busy[ia] = 1'b1;
        end
        n_cyc++;
    endtask

    // Monitor: samples just before each rising edge, after inputs settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                for (int k = 0; k < NUM_RD; k++) begin
                    n_checks++;
                    if (rd_data[k*XLEN +: XLEN] !== e.data[k*XLEN +: XLEN]) begin
                        n_errors++;
                        $display("FAIL rd_data[%0d] cyc %0d: got %h expected %h", k, e.cyc,
                                 rd_data[k*XLEN +: XLEN], e.data[k*XLEN +: XLEN]);
                    end
                end
                n_checks++;
                if (rd_busy !== e.rbusy) begin
                    n_errors++;
                    $display("FAIL rd_busy cyc %0d: got %b expected %b", e.cyc, rd_busy, e.rbusy);
                end
                n_checks++;
                if (busy_vec !== e.bvec) begin
                    n_errors++;
                    $display("FAIL busy_vec cyc %0d: got %h expected %h", e.cyc, busy_vec, e.bvec);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Reset contents and busy state
        cyc(1, 0, 5,  0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 31, 1, 3, 32'h1, 0, 0, 0, 1, 3);
        cyc(0, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0);
        // Write latency / bypass
        cyc(0, 3, 3,  1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 3, 7,  1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
        cyc(0, 7, 0,  0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        cyc(0, 7, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard set / clear / issue-beats-writeback
        cyc(0, 0, 9,  0, 0, 0, 0, 0, 0, 1, 9);
        cyc(0, 9, 9,  1, 9, 32'h55, 0, 0, 0, 0, 0);
        cyc(0, 9, 0,  0, 0, 0, 1, 9, 32'h66, 1, 9);
        cyc(0, 9, 0,  1, 9, 32'h77, 0, 0, 0, 1, 0);
        cyc(0, 9, 0,  0, 0, 0, 0, 0, 0, 1, 4);
        cyc(0, 4, 6,  0, 0, 0, 0, 0, 0, 1, 6);
        cyc(0, 4, 6,  0, 0, 0, 0, 0, 0, 0, 0);
        // Async reset overrides in-flight write/issue
        cyc(0, 12, 0, 1, 12, 32'hAAAA, 0, 0, 0, 1, 12);
        cyc(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 12, 0, 1, 12, 32'h1234, 1, 12, 32'h5678, 1, 12);
        cyc(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic, narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a0, a1, w0, w1, ia;
            a0 = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom);
            a1 = AW'($urandom);
            w0 = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom);
            w1 = ($urandom_range(0, 2) == 0) ? w0 : AW'($urandom);
            ia = ($urandom_range(0, 2) == 0) ? w1 : AW'($urandom);
            cyc(($urandom_range(0, 63) == 0), a0, a1,
                1'($urandom), w0, $urandom,
                1'($urandom), w1, $urandom,
                1'($urandom), ia);
        end
        drv_done = 1'b1;
        repeat (2) @(negedge clock);
        #4;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
